// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, S-box table and GF(2^8) helpers.
// Imported by the iterative core and its round datapath.
package aes_pkg;

  typedef enum logic [1:0] {
    AES_IDLE  = 2'd0,
    AES_INIT  = 2'd1,
    AES_ROUND = 2'd2,
    AES_DONE  = 2'd3
  } aes_state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Zero flags an unsupported key length.
  function automatic int nr_of(input int key_len);
    case (key_len)
      128:     return 10;
      192:     return 12;
      256:     return 14;
      default: return 0;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX[b];
  endfunction

endpackage

// File: rtl/aes_iter_if.sv
// aes_iter_if: plain text, round key and cipher text handshakes
// between a host (master) and the iterative AES core (slave).
interface aes_iter_if #(
  parameter int NO_ROWS = 4,
  parameter int NO_COLS = 4
);
  typedef logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] mat_t;

  logic       plain_text_vld_i;
  mat_t       plain_text_i;
  logic       plain_text_rdy_o;
  logic       key_req_o;
  logic [3:0] key_sel_o;
  logic       key_vld_i;
  mat_t       round_key_i;
  logic       cipher_text_rdy_o;
  logic       cipher_text_ack_i;
  mat_t       cipher_text_o;

  modport master (
    output plain_text_vld_i, plain_text_i,
    output key_vld_i, round_key_i,
    output cipher_text_ack_i,
    input  plain_text_rdy_o, key_req_o,
    input  key_sel_o, cipher_text_rdy_o,
    input  cipher_text_o
  );

  modport slave (
    input  plain_text_vld_i, plain_text_i,
    input  key_vld_i, round_key_i,
    input  cipher_text_ack_i,
    output plain_text_rdy_o, key_req_o,
    output key_sel_o, cipher_text_rdy_o,
    output cipher_text_o
  );
endinterface

// File: rtl/aes_round_comb.sv
// aes_round_comb: SubBytes, ShiftRows and (unless last) MixColumns.
// Purely combinational; the round key XOR happens in the core.
module aes_round_comb
  import aes_pkg::*;
#(
  parameter int NO_ROWS = 4,
  parameter int NO_COLS = 4
) (
  input  logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] state,
  input  logic                                 last_round,
  output logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] result
);
  typedef logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] mat_t;

  mat_t sb;
  mat_t sr;
  mat_t mc;

  always_comb begin
    sb = '0;
    sr = '0;
    mc = '0;
    for (int r = 0; r < NO_ROWS; r++) begin
      for (int c = 0; c < NO_COLS; c++) begin
        sb[r][c] = sub_byte(state[r][c]);
      end
    end
    for (int r = 0; r < NO_ROWS; r++) begin
      for (int c = 0; c < NO_COLS; c++) begin
        sr[r][c] = sb[r][(c + r) % NO_COLS];
      end
    end
    // Each output byte is 2*a0 ^ 3*a1 ^ a2 ^ a3, rotated per row.
    for (int c = 0; c < NO_COLS; c++) begin
      for (int r = 0; r < NO_ROWS; r++) begin
        mc[r][c] = xtime(sr[r][c])
                 ^ xtime(sr[(r + 1) % NO_ROWS][c])
                 ^ sr[(r + 1) % NO_ROWS][c]
                 ^ sr[(r + 2) % NO_ROWS][c]
                 ^ sr[(r + 3) % NO_ROWS][c];
      end
    end
    result = last_round ? sr : mc;
  end

endmodule

// File: rtl/aes_iter_core.sv
// aes_iter_core: iterative AES encryptor, one round per key beat.
// Round keys are fetched on demand through key_req_o/key_sel_o.
module aes_iter_core
  import aes_pkg::*;
#(
  parameter int NO_ROWS = 4,
  parameter int NO_COLS = 4,
  parameter int KEY_LEN = 128
) (
  input logic       aes_clk,
  input logic       resetn,
  input logic       aes_core_en,
  aes_iter_if.slave bus
);
  typedef logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] mat_t;

  localparam int         NR   = nr_of(KEY_LEN);
  localparam logic [3:0] NR_L = 4'(NR);

  localparam logic [1:0] ST_IDLE  = 2'(AES_IDLE);
  localparam logic [1:0] ST_INIT  = 2'(AES_INIT);
  localparam logic [1:0] ST_ROUND = 2'(AES_ROUND);
  localparam logic [1:0] ST_DONE  = 2'(AES_DONE);

  if (NR == 0) begin : g_bad_key_len
    $error("aes_iter_core: KEY_LEN must be 128, 192 or 256");
  end

  logic [1:0] fsm_q;
  logic [3:0] cnt_q;
  mat_t       st_q;
  mat_t       ct_q;
  mat_t       rnd;
  logic       pt_rdy_q;
  logic       key_req_q;
  logic [3:0] key_sel_q;
  logic       ct_rdy_q;
  logic       last;
  logic       key_fire;

  assign last     = (cnt_q == NR_L);
  assign key_fire = key_req_q & bus.key_vld_i;

  aes_round_comb #(
    .NO_ROWS (NO_ROWS),
    .NO_COLS (NO_COLS)
  ) u_round (
    .state      (st_q),
    .last_round (last),
    .result     (rnd)
  );

  always_ff @(posedge aes_clk or negedge resetn) begin
    if (!resetn) begin
      fsm_q     <= ST_IDLE;
      cnt_q     <= '0;
      st_q      <= '0;
      ct_q      <= '0;
      pt_rdy_q  <= 1'b1;
      key_req_q <= 1'b0;
      key_sel_q <= '0;
      ct_rdy_q  <= 1'b0;
    end else if (!aes_core_en) begin
      // Abort drops the block but keeps the last cipher text visible.
      fsm_q     <= ST_IDLE;
      cnt_q     <= '0;
      pt_rdy_q  <= 1'b1;
      key_req_q <= 1'b0;
      key_sel_q <= '0;
      ct_rdy_q  <= 1'b0;
    end else begin
      unique case (1'b1)
        (fsm_q == ST_IDLE): begin
          if (bus.plain_text_vld_i) begin
            st_q      <= bus.plain_text_i;
            cnt_q     <= '0;
            pt_rdy_q  <= 1'b0;
            key_req_q <= 1'b1;
            key_sel_q <= '0;
            fsm_q     <= ST_INIT;
          end
        end
        (fsm_q == ST_INIT): begin
          if (key_fire) begin
            st_q      <= st_q ^ bus.round_key_i;
            cnt_q     <= 4'd1;
            key_sel_q <= 4'd1;
            fsm_q     <= ST_ROUND;
          end
        end
        (fsm_q == ST_ROUND): begin
          if (key_fire && last) begin
            ct_q      <= rnd ^ bus.round_key_i;
            ct_rdy_q  <= 1'b1;
            key_req_q <= 1'b0;
            key_sel_q <= '0;
            cnt_q     <= '0;
            fsm_q     <= ST_DONE;
          end else if (key_fire) begin
            st_q      <= rnd ^ bus.round_key_i;
            cnt_q     <= cnt_q + 4'd1;
            key_sel_q <= cnt_q + 4'd1;
          end
        end
        (fsm_q == ST_DONE): begin
          if (bus.cipher_text_ack_i) begin
            ct_rdy_q <= 1'b0;
            pt_rdy_q <= 1'b1;
            fsm_q    <= ST_IDLE;
          end
        end
        default: fsm_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.plain_text_rdy_o  = pt_rdy_q;
  assign bus.key_req_o         = key_req_q;
  assign bus.key_sel_o         = key_sel_q;
  assign bus.cipher_text_rdy_o = ct_rdy_q;
  assign bus.cipher_text_o     = ct_q;

endmodule

// File: tb/tb_aes_iter_core.sv
// tb_aes_iter_core: drives AES-128/192/256 cores against a byte-level
// AES model whose S-box is derived from GF(2^8) inversion.
module tb_aes_iter_core;
  typedef logic [3:0][3:0][7:0] blk_t;

  logic         aes_clk = 1'b0;
  logic         resetn;
  logic [2:0]   en;
  logic [2:0]   vld;
  logic [2:0]   kv;
  logic [2:0]   ack;
  blk_t         pt [3];
  blk_t         rk [3];
  logic [2:0]   pt_rdy;
  logic [2:0]   key_req;
  logic [2:0]   ct_rdy;
  logic [3:0]   key_sel [3];
  blk_t         ct [3];
  logic [7:0]   sbt [256];
  logic [127:0] rkv [3][15];
  int           checks = 0;
  int           passes = 0;

  always #5 aes_clk = ~aes_clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_iter_if #(.NO_ROWS(4), .NO_COLS(4)) u_if ();
    assign u_if.plain_text_vld_i  = vld[g];
    assign u_if.plain_text_i      = pt[g];
    assign u_if.key_vld_i         = kv[g];
    assign u_if.round_key_i       = rk[g];
    assign u_if.cipher_text_ack_i = ack[g];
    assign pt_rdy[g]  = u_if.plain_text_rdy_o;
    assign key_req[g] = u_if.key_req_o;
    assign key_sel[g] = u_if.key_sel_o;
    assign ct_rdy[g]  = u_if.cipher_text_rdy_o;
    assign ct[g]      = u_if.cipher_text_o;
    aes_iter_core #(
      .NO_ROWS (4),
      .NO_COLS (4),
      .KEY_LEN (128 + 64 * g)
    ) u_dut (
      .aes_clk     (aes_clk),
      .resetn      (resetn),
      .aes_core_en (en[g]),
      .bus         (u_if)
    );
  end

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v,
                                       input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  task automatic build_sbox;
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, 8'(x));
      end
      sbt[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2)
             ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic blk_t to_mat(input logic [127:0] v);
    blk_t m;
    for (int n = 0; n < 16; n++) m[n % 4][n / 4] = v[127 - 8 * n -: 8];
    return m;
  endfunction

  function automatic logic [127:0] from_mat(input blk_t m);
    logic [127:0] v;
    for (int n = 0; n < 16; n++) v[127 - 8 * n -: 8] = m[n % 4][n / 4];
    return v;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbt[t[31:24]], sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]]};
  endfunction

  task automatic expand(input int d, input logic [255:0] key);
    int nk;
    int nr;
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0] rc;
    nk = 4 + 2 * d;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i - 1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i - nk] ^ t;
    end
    for (int r = 0; r <= nr; r++)
      rkv[d][r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  function automatic logic [7:0] coef(input int i);
    case (i)
      0:       return 8'h02;
      1:       return 8'h03;
      default: return 8'h01;
    endcase
  endfunction

  function automatic logic [127:0] enc(input logic [127:0] p,
                                       input int d);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [7:0] acc;
    logic [127:0] k;
    int nr;
    nr = 10 + 2 * d;
    k = rkv[d][0];
    for (int n = 0; n < 16; n++)
      b[n] = p[127 - 8 * n -: 8] ^ k[127 - 8 * n -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int n = 0; n < 16; n++) t[n] = sbt[b[n]];
      for (int row = 0; row < 4; row++)
        for (int c = 0; c < 4; c++)
          b[row + 4 * c] = t[row + 4 * ((c + row) % 4)];
      if (r < nr) begin
        for (int n = 0; n < 16; n++) t[n] = b[n];
        for (int c = 0; c < 4; c++)
          for (int row = 0; row < 4; row++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++)
              acc = acc ^ gmul(coef((j - row + 4) % 4), t[4 * c + j]);
            b[row + 4 * c] = acc;
          end
      end
      k = rkv[d][r];
      for (int n = 0; n < 16; n++) b[n] = b[n] ^ k[127 - 8 * n -: 8];
    end
    for (int n = 0; n < 16; n++) p[127 - 8 * n -: 8] = b[n];
    return p;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [255:0] rnd256();
    return {rnd128(), rnd128()};
  endfunction

  // Feeds one block, serves round keys, returns at cipher ready
  // or as soon as key_sel_o reaches stop_sel.
  task automatic run_block(input int d, input logic [127:0] ptv,
                           input int stall, input int stop_sel,
                           output logic [127:0] ctv, output int lat,
                           output int nkeys, output logic sel_ok);
    int w;
    lat = -1;
    nkeys = 0;
    sel_ok = 1'b1;
    w = 0;
    while (!pt_rdy[d] && w < 50) begin
      @(negedge aes_clk);
      w++;
    end
    pt[d] = to_mat(ptv);
    vld[d] = 1'b1;
    @(negedge aes_clk);
    vld[d] = 1'b0;
    for (int k = 0; k < 400; k++) begin
      kv[d] = 1'b0;
      if (ct_rdy[d]) begin
        lat = k;
        break;
      end
      if (key_req[d]) begin
        if (int'(key_sel[d]) == stop_sel) begin
          ctv = from_mat(ct[d]);
          return;
        end
        if (int'(key_sel[d]) != nkeys) sel_ok = 1'b0;
        rk[d] = to_mat(rkv[d][key_sel[d]]);
        kv[d] = ($urandom_range(99) >= stall);
        if (kv[d]) nkeys++;
      end
      @(negedge aes_clk);
    end
    ctv = from_mat(ct[d]);
  endtask

  task automatic do_ack(input int d, output logic [1:0] st);
    ack[d] = 1'b1;
    @(negedge aes_clk);
    ack[d] = 1'b0;
    st = {ct_rdy[d], pt_rdy[d]};
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (2) @(negedge aes_clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({pt_rdy[d], key_req[d], key_sel[d], ct_rdy[d]} !== 7'b1000000)
        $display("FAIL reset_ctrl dut%0d got %b want 1000000", d,
                 {pt_rdy[d], key_req[d], key_sel[d], ct_rdy[d]});
      else passes++;
      checks++;
      if (ct[d] !== '0)
        $display("FAIL reset_ct dut%0d got %h want 0", d, ct[d]);
      else passes++;
    end
    resetn = 1'b1;
    @(negedge aes_clk);
  endtask

  task automatic test_kat;
    logic [255:0] key [3];
    logic [127:0] want [3];
    logic [127:0] got;
    logic [127:0] ptv;
    logic [1:0] st;
    int lat;
    int nk;
    logic sok;
    ptv = 128'h00112233445566778899aabbccddeeff;
    key[0] = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    key[1] = {192'h000102030405060708090a0b0c0d0e0f1011121314151617,
              64'h0};
    key[2] = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    want[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    want[1] = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    want[2] = 128'h8ea2b7ca516745bfeafc49904b496089;
    for (int d = 0; d < 3; d++) begin
      expand(d, key[d]);
      run_block(d, ptv, 0, -1, got, lat, nk, sok);
      checks++;
      if (got !== want[d])
        $display("FAIL kat_ct dut%0d got %h want %h", d, got, want[d]);
      else passes++;
      checks++;
      if (lat !== 11 + 2 * d)
        $display("FAIL kat_latency dut%0d got %0d want %0d", d, lat,
                 11 + 2 * d);
      else passes++;
      checks++;
      if (sok !== 1'b1 || nk !== 11 + 2 * d)
        $display("FAIL kat_keys dut%0d sel_ok %b keys %0d want 1 %0d",
                 d, sok, nk, 11 + 2 * d);
      else passes++;
      do_ack(d, st);
      checks++;
      if (st !== 2'b01)
        $display("FAIL kat_ack dut%0d got %b want 01", d, st);
      else passes++;
    end
  endtask

  task automatic test_random;
    logic [127:0] ptv;
    logic [127:0] got;
    logic [127:0] want;
    logic [1:0] st;
    int lat;
    int nk;
    logic sok;
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 3; i++) begin
        expand(d, rnd256());
        ptv = rnd128();
        want = enc(ptv, d);
        run_block(d, ptv, 0, -1, got, lat, nk, sok);
        checks++;
        if (got !== want || lat !== 11 + 2 * d)
          $display("FAIL random_ct dut%0d got %h lat %0d want %h lat %0d",
                   d, got, lat, want, 11 + 2 * d);
        else passes++;
        do_ack(d, st);
        checks++;
        if (st !== 2'b01)
          $display("FAIL random_ack dut%0d got %b want 01", d, st);
        else passes++;
      end
    end
  endtask

  task automatic test_stall;
    logic [127:0] ptv;
    logic [127:0] got;
    logic [127:0] want;
    logic [1:0] st;
    int lat;
    int nk;
    logic sok;
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 2; i++) begin
        expand(d, rnd256());
        ptv = rnd128();
        want = enc(ptv, d);
        run_block(d, ptv, 50, -1, got, lat, nk, sok);
        checks++;
        if (got !== want)
          $display("FAIL stall_ct dut%0d got %h want %h", d, got, want);
        else passes++;
        checks++;
        if (sok !== 1'b1 || nk !== 11 + 2 * d)
          $display("FAIL stall_keys dut%0d sel_ok %b keys %0d want 1 %0d",
                   d, sok, nk, 11 + 2 * d);
        else passes++;
        do_ack(d, st);
      end
    end
  endtask

  task automatic test_ack_hold;
    logic [127:0] ptv;
    logic [127:0] got;
    logic [127:0] want;
    logic [1:0] st;
    int lat;
    int nk;
    logic sok;
    logic hold_ok;
    expand(0, rnd256());
    ptv = rnd128();
    want = enc(ptv, 0);
    run_block(0, ptv, 0, -1, got, lat, nk, sok);
    hold_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      vld[0] = 1'($urandom_range(1));
      kv[0] = 1'($urandom_range(1));
      pt[0] = to_mat(rnd128());
      @(negedge aes_clk);
      if (ct_rdy[0] !== 1'b1 || pt_rdy[0] !== 1'b0 ||
          key_req[0] !== 1'b0 || from_mat(ct[0]) !== want)
        hold_ok = 1'b0;
    end
    vld[0] = 1'b0;
    kv[0] = 1'b0;
    checks++;
    if (hold_ok !== 1'b1)
      $display("FAIL hold_stable got %b want 1", hold_ok);
    else passes++;
    checks++;
    if (from_mat(ct[0]) !== want)
      $display("FAIL hold_ct got %h want %h", from_mat(ct[0]), want);
    else passes++;
    do_ack(0, st);
    checks++;
    if (st !== 2'b01) $display("FAIL hold_ack got %b want 01", st);
    else passes++;
    ptv = rnd128();
    want = enc(ptv, 0);
    run_block(0, ptv, 0, -1, got, lat, nk, sok);
    checks++;
    if (got !== want || lat !== 11)
      $display("FAIL hold_next got %h lat %0d want %h lat 11",
               got, lat, want);
    else passes++;
    do_ack(0, st);
  endtask

  task automatic test_abort_en;
    logic [127:0] ptv;
    logic [127:0] got;
    logic [127:0] prev;
    logic [127:0] want;
    logic [1:0] st;
    int lat;
    int nk;
    logic sok;
    logic quiet;
    expand(0, rnd256());
    ptv = rnd128();
    prev = enc(ptv, 0);
    run_block(0, ptv, 0, -1, got, lat, nk, sok);
    do_ack(0, st);
    run_block(0, rnd128(), 0, 5, got, lat, nk, sok);
    en[0] = 1'b0;
    @(negedge aes_clk);
    checks++;
    if ({pt_rdy[0], key_req[0], ct_rdy[0]} !== 3'b100)
      $display("FAIL abort_en_ctrl got %b want 100",
               {pt_rdy[0], key_req[0], ct_rdy[0]});
    else passes++;
    checks++;
    if (from_mat(ct[0]) !== prev)
      $display("FAIL abort_en_ct got %h want %h", from_mat(ct[0]), prev);
    else passes++;
    en[0] = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 20; i++) begin
      kv[0] = 1'($urandom_range(1));
      @(negedge aes_clk);
      if (ct_rdy[0] !== 1'b0 || key_req[0] !== 1'b0) quiet = 1'b0;
    end
    kv[0] = 1'b0;
    checks++;
    if (quiet !== 1'b1) $display("FAIL abort_en_quiet got %b want 1", quiet);
    else passes++;
    ptv = rnd128();
    want = enc(ptv, 0);
    run_block(0, ptv, 0, -1, got, lat, nk, sok);
    checks++;
    if (got !== want)
      $display("FAIL abort_en_next got %h want %h", got, want);
    else passes++;
    do_ack(0, st);
  endtask

  task automatic test_abort_rst;
    logic [127:0] ptv;
    logic [127:0] got;
    logic [127:0] want;
    logic [1:0] st;
    int lat;
    int nk;
    logic sok;
    logic quiet;
    expand(1, rnd256());
    run_block(1, rnd128(), 0, 7, got, lat, nk, sok);
    resetn = 1'b0;
    #2;
    checks++;
    if ({pt_rdy[1], key_req[1], key_sel[1], ct_rdy[1]} !== 7'b1000000)
      $display("FAIL abort_rst_ctrl got %b want 1000000",
               {pt_rdy[1], key_req[1], key_sel[1], ct_rdy[1]});
    else passes++;
    checks++;
    if (ct[1] !== '0) $display("FAIL abort_rst_ct got %h want 0", ct[1]);
    else passes++;
    @(negedge aes_clk);
    resetn = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge aes_clk);
      if (ct_rdy[1] !== 1'b0 || key_req[1] !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (quiet !== 1'b1)
      $display("FAIL abort_rst_quiet got %b want 1", quiet);
    else passes++;
    ptv = rnd128();
    want = enc(ptv, 1);
    run_block(1, ptv, 0, -1, got, lat, nk, sok);
    checks++;
    if (got !== want || lat !== 13)
      $display("FAIL abort_rst_next got %h lat %0d want %h lat 13",
               got, lat, want);
    else passes++;
    do_ack(1, st);
  endtask

  initial begin
    resetn = 1'b0;
    en = 3'b111;
    vld = 3'b000;
    kv = 3'b000;
    ack = 3'b000;
    for (int d = 0; d < 3; d++) begin
      pt[d] = '0;
      rk[d] = '0;
    end
    build_sbox();
    test_reset();
    test_kat();
    test_random();
    test_stall();
    test_ack_hold();
    test_abort_en();
    test_abort_rst();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/aes_iter_core.md
AES_ITER_CORE -- requirements
Module: aes_iter_core

Interface
REQ-001 SHALL have parameter NO_ROWS, default 4, state rows; NO_COLS, default 4, state columns.
REQ-002 SHALL have parameter KEY_LEN, default 128, key length in bits, legal values 128/192/256.
REQ-003 SHALL have aes_clk  input  1  single clock, all logic rising-edge.
REQ-004 SHALL have resetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have aes_core_en  input  1  core enable.
REQ-006 SHALL have plain_text_vld_i  input  1  plain text valid.
REQ-007 SHALL have plain_text_i  input  8 x [NO_ROWS][NO_COLS]  plain text matrix; FIPS byte n at [n%4][n/4].
REQ-008 SHALL have plain_text_rdy_o  output  1  core can accept plain text.
REQ-009 SHALL have key_req_o  output  1  round key requested.
REQ-010 SHALL have key_sel_o  output  4  index of the requested round key, 0..NR.
REQ-011 SHALL have key_vld_i  input  1  round_key_i is valid for key_sel_o.
REQ-012 SHALL have round_key_i  input  8 x [NO_ROWS][NO_COLS]  round key matrix, same byte mapping.
REQ-013 SHALL have cipher_text_rdy_o  output  1  cipher text valid.
REQ-014 SHALL have cipher_text_ack_i  input  1  cipher text consumed.
REQ-015 SHALL have cipher_text_o  output  8 x [NO_ROWS][NO_COLS]  cipher text matrix.

Function
REQ-016 SHALL derive NR = 10/12/14 for KEY_LEN 128/192/256; any other KEY_LEN SHALL be an elaboration error.
REQ-017 SHALL implement FSM IDLE -> INIT -> ROUND -> DONE -> IDLE, registered state, registered outputs.
REQ-018 IDLE: plain_text_rdy_o=1; plain_text_vld_i & aes_core_en SHALL latch plain_text_i into the state register, set round counter 0, go INIT.
REQ-019 INIT: key_req_o=1, key_sel_o=0; on key_vld_i, state <= state ^ round_key_i, counter <= 1, go ROUND.
REQ-020 ROUND: key_req_o=1, key_sel_o=counter; on key_vld_i, state <= MixColumns(ShiftRows(SubBytes(state))) ^ round_key_i for counter < NR.
REQ-021 ROUND with counter == NR: MixColumns SHALL be omitted; result SHALL load cipher_text_o, cipher_text_rdy_o <= 1, go DONE.
REQ-022 Exactly one round SHALL complete per accepted key beat; with key_vld_i held high, cipher_text_rdy_o SHALL rise NR+1 cycles after the plain text accept edge.
REQ-023 key_vld_i while key_req_o=0 SHALL be ignored; key_sel_o SHALL stay stable while key_req_o=1 and key_vld_i=0.
REQ-024 DONE: cipher_text_rdy_o and cipher_text_o SHALL hold until cipher_text_ack_i; on ack, clear cipher_text_rdy_o, go IDLE (plain_text_rdy_o=1 the next cycle).
REQ-025 plain_text_rdy_o SHALL be 0 in INIT, ROUND and DONE; plain_text_vld_i there SHALL be ignored.
REQ-026 aes_core_en=0 in any state SHALL synchronously abort to IDLE, clearing key_req_o and cipher_text_rdy_o; cipher_text_o SHALL retain its value.
REQ-027 SubBytes SHALL use the FIPS-197 forward S-box; xtime SHALL use reduction polynomial 0x11B.
REQ-028 ShiftRows SHALL rotate row r left by r positions, modulo NO_COLS.

Reset
REQ-029 resetn low SHALL asynchronously force IDLE, counter 0, plain_text_rdy_o=1, key_req_o=0, key_sel_o=0, cipher_text_rdy_o=0, cipher_text_o all 0, state register 0.
REQ-030 Reset mid-operation SHALL discard the block in progress with no cipher text output.

Structure
REQ-031 SHALL use shared package aes_pkg holding the FSM state enum, the S-box table, the KEY_LEN-to-NR function and the xtime function.
REQ-032 SHALL instantiate one combinational sub-module aes_round_comb (inputs: state, last_round flag; output: transformed state, before key XOR).

Verification
REQ-033 AES-128, key_vld_i tied 1, PT 00112233445566778899aabbccddeeff, key 000102..0f expansion -> CT 69c4e0d86a7b0430d8cdb78070b4c55a at cycle 11.
REQ-034 KEY_LEN=192, key 000102..17 -> CT dda97ca4864cdfe06eaf70a0ec0d7191, key_sel_o 0..12; KEY_LEN=256, key 000102..1f -> CT 8ea2b7ca516745bfeafc49904b496089, key_sel_o 0..14.
REQ-035 Random key_vld_i stalls (about 50%) -> same CT; key_sel_o stable during stalls; exactly NR+1 keys consumed.
REQ-036 cipher_text_ack_i withheld 20 cycles -> CT and rdy held; plain_text_vld_i pulsed meanwhile is ignored; after ack, the next block is accepted.
REQ-037 aes_core_en dropped at round 5, and separately resetn asserted at round 7 -> IDLE, no cipher_text_rdy_o; the following block produces the correct CT.
